// File: rtl/pipeline_hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle.
// master: datapath side (drives hazard inputs); slave: controller side (drives strobes/counters).
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       id_rn;
    logic [4:0]       id_rm;
    logic             id_uses_rn;
    logic             id_uses_rm;
    logic [4:0]       ex_rd;
    logic             ex_memRead;
    logic             ex_regWrite;
    logic [4:0]       mem_rd;
    logic             mem_regWrite;
    logic             mem_access;
    logic             dm_ready;
    logic             pcsrc;

    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             mem_wb_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rn, id_rm, id_uses_rn, id_uses_rm, ex_rd, ex_memRead, ex_regWrite,
               mem_rd, mem_regWrite, mem_access, dm_ready, pcsrc,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rn, id_rm, id_uses_rn, id_uses_rm, ex_rd, ex_memRead, ex_regWrite,
               mem_rd, mem_regWrite, mem_access, dm_ready, pcsrc,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stage enable/flush sequencer for the 5-stage pipeline: load-use/RAW stalls, branch flush,
// data-memory waits with watchdog. Define FWD_EN when the datapath has EX forwarding.
module pipeline_hazard_ctrl #(
    parameter int unsigned N           = 64,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input logic                   clk,
    input logic                   reset,
    pipeline_hazard_ctrl_if.slave hz
);

    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 65535 || CNT_W < 1 || N < CNT_W) begin : gBadParams
        $error("pipeline_hazard_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {StRun, StMemWait, StHalt} state_e;

    localparam logic [15:0] TimeoutVal = 16'(MEM_TIMEOUT);

    state_e           state;
    logic [15:0]      waitCnt;
    logic [15:0]      nextWait;
    logic             haltedQ;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    logic [4:0] en;     // {pc, ifId, idEx, exMem, memWb}
    logic [3:0] fl;     // {ifId, idEx, exMem, memWb}
    logic       memWait;
    logic       branchTaken;
    logic       hazard;
    logic       exMatch;

    assign exMatch = (hz.ex_rd != 5'd31) &
                     ((hz.id_uses_rn & (hz.id_rn == hz.ex_rd)) |
                      (hz.id_uses_rm & (hz.id_rm == hz.ex_rd)));

`ifdef FWD_EN
    // Forwarding covers everything except a load whose data arrives after EX.
    assign hazard = hz.ex_memRead & exMatch;

    logic unusedNoFwd;
    assign unusedNoFwd = ^{hz.ex_regWrite, hz.mem_rd, hz.mem_regWrite};
`else
    logic memMatch;
    assign memMatch = (hz.mem_rd != 5'd31) &
                      ((hz.id_uses_rn & (hz.id_rn == hz.mem_rd)) |
                       (hz.id_uses_rm & (hz.id_rm == hz.mem_rd)));
    // WB is not checked: the regfile writes before it is read in the same cycle.
    assign hazard = (hz.ex_regWrite & exMatch) | (hz.mem_regWrite & memMatch);

    logic unusedFwd;
    assign unusedFwd = hz.ex_memRead;
`endif

    assign nextWait = waitCnt + 16'd1;

    always_comb begin
        en          = '1;
        fl          = '0;
        memWait     = 1'b0;
        branchTaken = 1'b0;
        if (!reset) begin
            en = '0;
            fl = '1;
        end else begin
            case (state)
                StHalt: begin
                    en = '0;
                end
                default: begin
                    memWait = !hz.dm_ready & (hz.mem_access | (state == StMemWait));
                    if (memWait) begin
                        // MEM_WB still loads, but takes a bubble (flush wins over en).
                        en[4:1] = '0;
                        fl[0]   = 1'b1;
                    end else if (hz.pcsrc) begin
                        branchTaken = 1'b1;
                        fl[3:1]     = '1;
                    end else if (hazard) begin
                        en[4:3] = '0;
                        fl[2]   = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= StRun;
            waitCnt  <= '0;
            haltedQ  <= 1'b0;
            stallCnt <= '0;
            flushCnt <= '0;
        end else if (state != StHalt) begin
            if (memWait) begin
                waitCnt <= nextWait;
                if (nextWait == TimeoutVal) begin
                    state   <= StHalt;
                    haltedQ <= 1'b1;
                end else begin
                    state <= StMemWait;
                end
            end else begin
                state   <= StRun;
                waitCnt <= '0;
            end
            if (!en[4] && stallCnt != '1) begin
                stallCnt <= stallCnt + 1'b1;
            end
            if (branchTaken && flushCnt != '1) begin
                flushCnt <= flushCnt + 1'b1;
            end
        end
    end

    assign hz.pc_en        = en[4];
    assign hz.if_id_en     = en[3];
    assign hz.id_ex_en     = en[2];
    assign hz.ex_mem_en    = en[1];
    assign hz.mem_wb_en    = en[0];
    assign hz.if_id_flush  = fl[3];
    assign hz.id_ex_flush  = fl[2];
    assign hz.ex_mem_flush = fl[1];
    assign hz.mem_wb_flush = fl[0];
    assign hz.halted       = haltedQ;
    assign hz.stall_cnt    = stallCnt;
    assign hz.flush_cnt    = flushCnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard scenarios plus random traffic,
// checked against a rule-level reference model. Honours FWD_EN like the design.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CntW       = 4;
    localparam int unsigned MemTimeout = 8;
    localparam int          CntMax     = (1 << CntW) - 1;

    // Strobe vector order: {pc, if_id, id_ex, ex_mem, mem_wb en, if_id, id_ex, ex_mem, mem_wb flush}
    localparam logic [8:0] SNormal = 9'b11111_0000;
    localparam logic [8:0] SReset  = 9'b00000_1111;
    localparam logic [8:0] SHalt   = 9'b00000_0000;
    localparam logic [8:0] SFreeze = 9'b00001_0001;
    localparam logic [8:0] SBranch = 9'b11111_1110;
    localparam logic [8:0] SStall  = 9'b00111_0100;

    typedef struct packed {
        logic [4:0] rn;
        logic [4:0] rm;
        logic       usesRn;
        logic       usesRm;
        logic [4:0] exRd;
        logic       exMemRead;
        logic       exRegWrite;
        logic [4:0] memRd;
        logic       memRegWrite;
        logic       memAccess;
        logic       dmReady;
        logic       pcsrc;
    } stim_t;

    typedef struct packed {
        logic [8:0]      strobes;
        logic            halted;
        logic [CntW-1:0] stall;
        logic [CntW-1:0] flush;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CntW)) hz ();

    pipeline_hazard_ctrl #(
        .N          (64),
        .CNT_W      (CntW),
        .MEM_TIMEOUT(MemTimeout)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .hz   (hz)
    );

    exp_t expQ[$];
    int   nChecks = 0;
    int   nFail   = 0;
    int   cycle   = 0;

    // Reference model state: consecutive wait cycles, halt flag, raw event counts.
    int mWait  = 0;
    bit mHalt  = 1'b0;
    int mStall = 0;
    int mFlush = 0;

    function automatic bit reads(input stim_t s, input logic [4:0] r);
        return (r != 5'd31) && ((s.usesRn && s.rn == r) || (s.usesRm && s.rm == r));
    endfunction

    function automatic bit isHazard(input stim_t s);
`ifdef FWD_EN
        return s.exMemRead && reads(s, s.exRd);
`else
        return (s.exRegWrite && reads(s, s.exRd)) || (s.memRegWrite && reads(s, s.memRd));
`endif
    endfunction

    function automatic logic [CntW-1:0] sat(input int v);
        return (v > CntMax) ? CntW'(CntMax) : CntW'(v);
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s         = '0;
        s.dmReady = 1'b1;
        return s;
    endfunction

    task automatic modelStep(input stim_t s, input logic rst);
        exp_t e;
        if (!rst) begin
            e      = '0;
            e.strobes = SReset;
            mWait  = 0;
            mHalt  = 1'b0;
            mStall = 0;
            mFlush = 0;
        end else begin
            e.halted = mHalt;
            e.stall  = sat(mStall);
            e.flush  = sat(mFlush);
            if (mHalt) begin
                e.strobes = SHalt;
            end else if (!s.dmReady && (s.memAccess || mWait > 0)) begin
                e.strobes = SFreeze;
                mStall++;
                mWait++;
                if (mWait >= MemTimeout) mHalt = 1'b1;
            end else begin
                mWait = 0;
                if (s.pcsrc) begin
                    e.strobes = SBranch;
                    mFlush++;
                end else if (isHazard(s)) begin
                    e.strobes = SStall;
                    mStall++;
                end else begin
                    e.strobes = SNormal;
                end
            end
        end
        expQ.push_back(e);
    endtask

    task automatic apply(input stim_t s, input logic rst);
        @(posedge clk);
        #1;
        reset           = rst;
        hz.id_rn        = s.rn;
        hz.id_rm        = s.rm;
        hz.id_uses_rn   = s.usesRn;
        hz.id_uses_rm   = s.usesRm;
        hz.ex_rd        = s.exRd;
        hz.ex_memRead   = s.exMemRead;
        hz.ex_regWrite  = s.exRegWrite;
        hz.mem_rd       = s.memRd;
        hz.mem_regWrite = s.memRegWrite;
        hz.mem_access   = s.memAccess;
        hz.dm_ready     = s.dmReady;
        hz.pcsrc        = s.pcsrc;
        modelStep(s, rst);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nFail++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, act, req);
        end
    endtask

    // Monitor: compares DUT outputs mid-cycle against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        cycle++;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check("strobes", 32'({hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en,
                                  hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush,
                                  hz.mem_wb_flush}), 32'(e.strobes));
            check("halted", 32'(hz.halted), 32'(e.halted));
            check("stall_cnt", 32'(hz.stall_cnt), 32'(e.stall));
            check("flush_cnt", 32'(hz.flush_cnt), 32'(e.flush));
        end
    end

    initial begin
        stim_t      s;
        logic [4:0] regs[4];
        regs[0] = 5'd1;
        regs[1] = 5'd2;
        regs[2] = 5'd3;
        regs[3] = 5'd31;
        s = idle();
        hz.id_rn = '0; hz.id_rm = '0; hz.id_uses_rn = 0; hz.id_uses_rm = 0;
        hz.ex_rd = '0; hz.ex_memRead = 0; hz.ex_regWrite = 0; hz.mem_rd = '0;
        hz.mem_regWrite = 0; hz.mem_access = 0; hz.dm_ready = 1; hz.pcsrc = 0;

        repeat (2) apply(idle(), 1'b0);
        apply(idle(), 1'b1);

        // ALU producer X1 in EX, consumer in ID, then producer moves on to MEM.
        s = idle(); s.exRd = 5'd1; s.exRegWrite = 1; s.rn = 5'd1; s.usesRn = 1; s.rm = 5'd3;
        s.usesRm = 1;
        apply(s, 1'b1);
        s.exRegWrite = 0; s.exRd = 5'd0; s.memRd = 5'd1; s.memRegWrite = 1;
        apply(s, 1'b1);
        s.memRegWrite = 0; s.memRd = 5'd0;
        apply(s, 1'b1);

        // Load X1 in EX, ADD X2,X1,X3 in ID, then the load moves to MEM.
        s = idle(); s.exRd = 5'd1; s.exMemRead = 1; s.exRegWrite = 1; s.rn = 5'd1; s.usesRn = 1;
        s.rm = 5'd3; s.usesRm = 1;
        apply(s, 1'b1);
        s.exMemRead = 0; s.exRegWrite = 0; s.exRd = 5'd0; s.memRd = 5'd1; s.memRegWrite = 1;
        apply(s, 1'b1);
        apply(idle(), 1'b1);

        // XZR destination and source never hazard.
        s = idle(); s.exRd = 5'd31; s.exMemRead = 1; s.exRegWrite = 1; s.rn = 5'd31; s.usesRn = 1;
        s.memRd = 5'd31; s.memRegWrite = 1;
        apply(s, 1'b1);

        // Taken branch while a load-use hazard is present.
        s = idle(); s.exRd = 5'd2; s.exMemRead = 1; s.exRegWrite = 1; s.rm = 5'd2; s.usesRm = 1;
        s.pcsrc = 1;
        apply(s, 1'b1);

        // Memory access waits three cycles, released on the fourth.
        s = idle(); s.memAccess = 1; s.dmReady = 0;
        repeat (3) apply(s, 1'b1);
        s.dmReady = 1;
        apply(s, 1'b1);
        apply(idle(), 1'b1);

        // Reset asserted in the middle of a wait.
        s = idle(); s.memAccess = 1; s.dmReady = 0;
        repeat (2) apply(s, 1'b1);
        repeat (2) apply(s, 1'b0);
        apply(idle(), 1'b1);

        // Memory stuck: watchdog halts, outputs freeze until reset.
        s = idle(); s.memAccess = 1; s.dmReady = 0;
        repeat (MemTimeout) apply(s, 1'b1);
        s.pcsrc = 1; s.dmReady = 1;
        repeat (3) apply(s, 1'b1);
        apply(idle(), 1'b0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            s.rn          = regs[$urandom_range(0, 3)];
            s.rm          = regs[$urandom_range(0, 3)];
            s.usesRn      = 1'($urandom_range(0, 1));
            s.usesRm      = 1'($urandom_range(0, 1));
            s.exRd        = regs[$urandom_range(0, 3)];
            s.exMemRead   = 1'($urandom_range(0, 2) == 0);
            s.exRegWrite  = 1'($urandom_range(0, 1));
            s.memRd       = regs[$urandom_range(0, 3)];
            s.memRegWrite = 1'($urandom_range(0, 1));
            s.memAccess   = 1'($urandom_range(0, 3) == 0);
            s.dmReady     = 1'($urandom_range(0, 3) != 0);
            s.pcsrc       = 1'($urandom_range(0, 6) == 0);
            if (i % 40 < 10) s.dmReady = 1'b0;
            apply(s, ($urandom_range(0, 99) == 0 || i % 200 == 199) ? 1'b0 : 1'b1);
        end

        // Drain the scoreboard, bounded.
        for (int k = 0; k < 10 && expQ.size() > 0; k++) @(posedge clk);
        if (expQ.size() != 0) begin
            nChecks++;
            nFail++;
            $display("FAIL drain: %0d entries left, expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage pipelined datapath: generates per-stage enable/flush strobes for PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- Covers load-use and RAW hazards, taken-branch flush (branch resolved in MEM stage), and multi-cycle data-memory waits, with a watchdog.
- Sits beside the datapath; pipeline registers consume en (hold when 0) and flush (load zero/bubble when 1, flush wins over en).

Parameters:
- N, 64, datapath width (kept for codebase consistency; unused internally except counter sizing checks)
- CNT_W, 16, width of performance counters
- MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before HALT (1..2^16-1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_rn  in  5  decode-stage source register Rn
- id_rm  in  5  decode-stage source register Rm/Rt (post reg2loc mux)
- id_uses_rn  in  1  decode instruction reads Rn
- id_uses_rm  in  1  decode instruction reads Rm/Rt
- ex_rd  in  5  ID_EX destination register
- ex_memRead  in  1  ID_EX memRead
- ex_regWrite  in  1  ID_EX regWrite
- mem_rd  in  5  EX_MEM destination register
- mem_regWrite  in  1  EX_MEM regWrite
- mem_access  in  1  EX_MEM memRead|memWrite
- dm_ready  in  1  data memory completes access this cycle
- pcsrc  in  1  taken branch resolved in MEM stage
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage enables
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  stage bubble inserts
- halted  out  1  sticky watchdog error
- stall_cnt  out  CNT_W  cycles with pc_en=0 in RUN/MEM_WAIT
- flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- FSM states: RUN, MEM_WAIT, HALT. Registered state; strobes are combinational from state + inputs (zero added latency).
- Reset (reset=0, async): state=RUN, halted=0, counters=0, wait counter=0. Outputs while in reset: all en=0, all flush=1.
- Register 31 (XZR) never creates a hazard; compares against 31 are suppressed.
- Priority per cycle: HALT > memory wait > branch flush > data hazard > normal.
- RUN, normal: all en=1, all flush=0.
- Memory wait: mem_access=1 and dm_ready=0 -> pc/if_id/id_ex/ex_mem en=0, mem_wb_flush=1; next state MEM_WAIT, wait counter=1.
- MEM_WAIT: same freeze strobes while dm_ready=0; wait counter increments. dm_ready=1 -> release cycle: all en=1, evaluate branch/hazard rules for that cycle, next RUN, counter cleared. Counter reaching MEM_TIMEOUT with dm_ready=0 -> HALT.
- Branch flush (pcsrc=1): pc_en=1 (loads target), if_id_flush=id_ex_flush=ex_mem_flush=1, mem_wb_en=1; flush_cnt+1 (saturating). Hazard rules ignored that cycle.
- Data hazard (stall): pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=mem_wb_en=1. Re-evaluated each cycle; stall persists until condition clears.
- HALT: all en=0, all flush=0 (pipeline frozen for inspection), halted=1; exit only by reset.
- stall_cnt/flush_cnt saturate at all-ones, never wrap.

Optional Feature:
- Macro FWD_EN.
- Defined: datapath has EX forwarding; hazard = ex_memRead & ex_rd!=31 & ((id_uses_rn & id_rn==ex_rd) | (id_uses_rm & id_rm==ex_rd)); max 1 stall cycle per load.
- Undefined: no forwarding; hazard = match against ex_rd with ex_regWrite OR against mem_rd with mem_regWrite (both excluding 31); ALU-to-ALU dependence stalls 2 cycles, load-use 2 cycles. Regfile WB-write/ID-read same cycle is write-first, so no WB check.

Test Plan:
- FWD_EN: LDUR X1 in EX, ADD X2,X1,X3 in ID -> exactly 1 cycle pc_en=0, id_ex_flush=1; stall_cnt=1.
- No FWD_EN: ADD X1 in EX, SUB reading X1 in ID -> 2 stall cycles, then normal; stall_cnt=2.
- ex_rd=31, ex_memRead=1, id_rn=31 -> no stall, all en=1.
- pcsrc=1 while load-use hazard present -> flushes win: if_id/id_ex/ex_mem_flush=1, pc_en=1, flush_cnt=1.
- mem_access=1, dm_ready low 3 cycles -> 3 cycles freeze + mem_wb_flush, release on 4th, state RUN; MEM_TIMEOUT=8 with dm_ready stuck low -> HALT after 8 cycles, halted=1.
- Assert reset mid-MEM_WAIT -> immediate RUN, counters 0, halted=0, all flush=1 until release.
